// File: rtl/uart_line_rx.sv
// uart_line_rx: 8N1 UART receiver feeding a line assembler.
// Incoming bytes are collected until a terminator arrives. The finished line is
// held for the consumer, which reads it through rd_addr/rd_data and releases it
// with line_ack. rts tells the peer transmitter to pause.
// Build option: define UART_RX_LINE_LF_EN to make 8'h0A a second terminator.
// Without it, 8'h0A is stored like any other data byte.
module uart_line_rx #(
    parameter int          CLKS_PER_BIT = 1085,
    parameter int          MAX_LEN      = 16,
    parameter logic [7:0]  TERM_CHAR    = 8'h0D
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        fsm_en,
    input  logic                                        serial_rx,
    output logic                                        rts,
    output logic                                        line_valid,
    output logic [$clog2(MAX_LEN+1)-1:0]                line_len,
    input  logic                                        line_ack,
    input  logic [(MAX_LEN > 1 ? $clog2(MAX_LEN) : 1)-1:0] rd_addr,
    output logic [7:0]                                  rd_data,
    output logic                                        frame_err,
    output logic                                        overflow,
    output logic                                        overrun
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [LEN_W-1:0] FULL      = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {A_COLLECT, A_DISCARD, A_HOLD}         asm_state_t;

    // ---------------- receiver ----------------
    logic [1:0]       sync_q;
    logic             rx_prev_q;
    logic             rx_bit;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_stb_q, byte_stb_d;
    logic             frame_err_q, frame_err_d;

    assign rx_bit = sync_q[1];

    // Two-flop synchronizer and previous-bit tracker for start-edge detection.
    // NOTE: state registers take only non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], serial_rx};
            rx_prev_q <= rx_bit;
        end
    end

    // Receiver next-state logic: start validation, mid-bit data sampling, stop check.
    // NOTE: every output is defaulted first so no path leaves a variable unassigned (no latches).
    always_comb begin
        rx_state_d  = rx_state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;
        if (!fsm_en) begin
            rx_state_d = RX_IDLE;
            clk_cnt_d  = '0;
            bit_idx_d  = '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    if (rx_prev_q && !rx_bit) rx_state_d = RX_START;
                end
                RX_START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_d  = '0;
                        rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_d = clk_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_d = '0;
                        shift_d   = {rx_bit, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                    end else begin
                        clk_cnt_d = clk_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_d   = '0;
                        byte_stb_d  = rx_bit;
                        frame_err_d = !rx_bit;
                        rx_state_d  = RX_IDLE;
                    end else begin
                        clk_cnt_d = clk_cnt_q + 1'b1;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q  <= RX_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_stb_q  <= byte_stb_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------- line assembler ----------------
    asm_state_t       asm_state_q, asm_state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] line_len_q, line_len_d;
    logic             line_valid_q, line_valid_d;
    logic             overflow_q, overflow_d;
    logic             overrun_q, overrun_d;
    logic             rts_q, rts_d;
    logic             wr_en;
    logic             is_term;
    logic [7:0]       buf_q [MAX_LEN];

    // shift_q is stable while byte_stb_q is high, so it serves as the received byte.
`ifdef UART_RX_LINE_LF_EN
    assign is_term = (shift_q == TERM_CHAR) || (shift_q == 8'h0A);
`else
    assign is_term = (shift_q == TERM_CHAR);
`endif

    // Assembler next-state logic: collect, discard after overflow, or hold a finished line.
    always_comb begin
        asm_state_d  = asm_state_q;
        count_d      = count_q;
        line_len_d   = line_len_q;
        line_valid_d = line_valid_q;
        overflow_d   = 1'b0;
        overrun_d    = 1'b0;
        wr_en        = 1'b0;
        if (!fsm_en) begin
            asm_state_d  = A_COLLECT;
            count_d      = '0;
            line_valid_d = 1'b0;
        end else begin
            case (asm_state_q)
                A_COLLECT: begin
                    if (byte_stb_q) begin
                        if (is_term) begin
                            line_len_d   = count_q;
                            line_valid_d = 1'b1;
                            count_d      = '0;
                            asm_state_d  = A_HOLD;
                        end else if (count_q == FULL) begin
                            overflow_d  = 1'b1;
                            count_d     = '0;
                            asm_state_d = A_DISCARD;
                        end else begin
                            wr_en   = 1'b1;
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                A_DISCARD: begin
                    if (byte_stb_q && is_term) asm_state_d = A_COLLECT;
                end
                A_HOLD: begin
                    overrun_d = byte_stb_q;
                    if (line_ack) begin
                        line_valid_d = 1'b0;
                        asm_state_d  = A_COLLECT;
                    end
                end
                default: asm_state_d = A_COLLECT;
            endcase
        end
        rts_d = !fsm_en || line_valid_d || (asm_state_d == A_DISCARD);
    end

    // Assembler state register; rts is registered from next-state so it moves with line_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_state_q  <= A_COLLECT;
            count_q      <= '0;
            line_len_q   <= '0;
            line_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            overrun_q    <= 1'b0;
            rts_q        <= 1'b1;
        end else begin
            asm_state_q  <= asm_state_d;
            count_q      <= count_d;
            line_len_q   <= line_len_d;
            line_valid_q <= line_valid_d;
            overflow_q   <= overflow_d;
            overrun_q    <= overrun_d;
            rts_q        <= rts_d;
        end
    end

    // Line buffer write port.
    // NOTE: the buffer is reset because reads after reset must return zeros; it is small enough to allow it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
        end else if (wr_en) begin
            buf_q[count_q[ADDR_W-1:0]] <= shift_q;
        end
    end

    assign rd_data    = (32'(rd_addr) < MAX_LEN) ? buf_q[rd_addr] : 8'h00;
    assign rts        = rts_q;
    assign line_valid = line_valid_q;
    assign line_len   = line_len_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign overrun    = overrun_q;

endmodule
